// File: rtl/recv_packet_1_if.sv
// Avalon-ST receive sink plus Avalon-MM write master used by recv_packet_1.
// The master modport is the receiver's view; slave is the attached environment.
interface recv_packet_1_if;
    logic [7:0]  ff_rx_data;
    logic        ff_rx_dval;
    logic        ff_rx_sop;
    logic        ff_rx_eop;
    logic        ff_rx_err;
    logic        ff_rx_rdy;
    logic [9:0]  ram_addr;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic [3:0]  ram_byteenable;
    logic        ram_waitrequest;

    modport master (
        input  ff_rx_data, ff_rx_dval, ff_rx_sop, ff_rx_eop, ff_rx_err,
        output ff_rx_rdy,
        output ram_addr, ram_chipselect, ram_write, ram_writedata, ram_byteenable,
        input  ram_waitrequest
    );

    modport slave (
        output ff_rx_data, ff_rx_dval, ff_rx_sop, ff_rx_eop, ff_rx_err,
        input  ff_rx_rdy,
        input  ram_addr, ram_chipselect, ram_write, ram_writedata, ram_byteenable,
        output ram_waitrequest
    );
endinterface

// File: rtl/recv_packet_1.sv
// Packet receiver: packs Avalon-ST bytes into 32-bit RAM words behind a header
// word, then kicks send_packet_1 and holds off new traffic for HOLDOFF cycles.
module recv_packet_1 #(
    parameter logic [9:0] BASE_ADDR = 10'd0,
    parameter int         MAX_BYTES = 1518,
    parameter int         HOLDOFF   = 2048
) (
    input  logic              clk_original,
    input  logic              rst,
    recv_packet_1_if.master   bus,
    output logic [24:0]       start_ram_addr,
    output logic              cmd_send,
    output logic [11:0]       rx_len,
    output logic              rx_drop
);

    localparam int                HOLD_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);
    localparam logic [11:0]       MAX_IDX   = 12'(MAX_BYTES);

    typedef enum logic [2:0] {
        IDLE, RECV, WR_WORD, WR_HDR, SEND, HOLD, DISCARD
    } state_t;

    state_t            state, state_nxt;
    logic [11:0]       byte_cnt;
    logic [11:0]       pkt_len;
    logic [31:0]       word_buf;
    logic              last_word;
    logic [HOLD_W-1:0] hold_cnt;

    logic              ready;
    logic              accept;
    logic              capture;
    logic              restart;
    logic              bad_eop;
    logic              overflow;
    logic              load_word;
    logic              wr_done;
    logic              drop_nxt;
    logic [11:0]       idx;
    logic [1:0]        lane;
    logic [3:0]        lane_mask;
    logic [31:0]       word_nxt;

    assign start_ram_addr = {15'd0, BASE_ADDR};
    assign bus.ff_rx_rdy  = ready;

    always_ff @(posedge clk_original) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = !rst && (state == IDLE || state == RECV || state == DISCARD);
        accept    = bus.ff_rx_dval && ready;
        // Outside a packet only a sop byte opens capture; stray bytes fall away.
        capture   = accept && (state == RECV || (state == IDLE && bus.ff_rx_sop));
        restart   = capture && bus.ff_rx_sop;
        idx       = restart ? 12'd0 : byte_cnt;
        lane      = idx[1:0];
        word_nxt  = ((lane == 2'd0) ? 32'd0 : word_buf)
                  | ({24'd0, bus.ff_rx_data} << {lane, 3'b000});
        case (lane)
            2'd0:    lane_mask = 4'b0001;
            2'd1:    lane_mask = 4'b0011;
            2'd2:    lane_mask = 4'b0111;
            default: lane_mask = 4'b1111;
        endcase
        bad_eop   = capture && bus.ff_rx_eop && bus.ff_rx_err;
        overflow  = capture && !bad_eop && (idx == MAX_IDX);
        load_word = capture && !bad_eop && !overflow && (bus.ff_rx_eop || lane == 2'd3);
        wr_done   = bus.ram_chipselect && !bus.ram_waitrequest;
        drop_nxt  = bad_eop || overflow || (restart && state == RECV);

        case (state)
            IDLE, RECV: begin
                if (bad_eop)        state_nxt = IDLE;
                else if (overflow)  state_nxt = bus.ff_rx_eop ? IDLE : DISCARD;
                else if (load_word) state_nxt = WR_WORD;
                else if (capture)   state_nxt = RECV;
            end
            WR_WORD: begin
                if (wr_done) state_nxt = last_word ? WR_HDR : RECV;
            end
            WR_HDR: begin
                if (wr_done) state_nxt = SEND;
            end
            SEND:    state_nxt = HOLD;
            HOLD: begin
                if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
            end
            DISCARD: begin
                if (accept && bus.ff_rx_eop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_original) begin
        if (rst) begin
            byte_cnt           <= 12'd0;
            pkt_len            <= 12'd0;
            word_buf           <= 32'd0;
            last_word          <= 1'b0;
            hold_cnt           <= '0;
            cmd_send           <= 1'b0;
            rx_len             <= 12'd0;
            rx_drop            <= 1'b0;
            bus.ram_addr       <= 10'd0;
            bus.ram_chipselect <= 1'b0;
            bus.ram_write      <= 1'b0;
            bus.ram_writedata  <= 32'd0;
            bus.ram_byteenable <= 4'd0;
        end else begin
            cmd_send <= 1'b0;
            rx_drop  <= drop_nxt;

            if (capture) begin
                byte_cnt <= idx + 12'd1;
                word_buf <= word_nxt;
            end

            // A full word or the closing eop byte launches a payload write.
            if (load_word) begin
                bus.ram_addr       <= BASE_ADDR + 10'd1 + idx[11:2];
                bus.ram_writedata  <= word_nxt;
                bus.ram_byteenable <= bus.ff_rx_eop ? lane_mask : 4'hF;
                bus.ram_chipselect <= 1'b1;
                bus.ram_write      <= 1'b1;
                last_word          <= bus.ff_rx_eop;
                pkt_len            <= idx + 12'd1;
            end

            case (state)
                WR_WORD: begin
                    if (wr_done) begin
                        if (last_word) begin
                            bus.ram_addr       <= BASE_ADDR;
                            bus.ram_writedata  <= {20'd0, pkt_len};
                            bus.ram_byteenable <= 4'hF;
                        end else begin
                            bus.ram_chipselect <= 1'b0;
                            bus.ram_write      <= 1'b0;
                        end
                    end
                end
                WR_HDR: begin
                    if (wr_done) begin
                        bus.ram_chipselect <= 1'b0;
                        bus.ram_write      <= 1'b0;
                        cmd_send           <= 1'b1;
                        rx_len             <= pkt_len;
                    end
                end
                default: ;
            endcase

            if (state == HOLD) hold_cnt <= hold_cnt + 1'b1;
            else               hold_cnt <= '0;
        end
    end

endmodule

// File: doc/recv_packet_1.md
RECV_PACKET_1 -- requirements
Module: recv_packet_1

Interface
REQ-001 Parameter BASE_ADDR, default 10'd0, is the RAM word address of the packet buffer; word BASE_ADDR holds the header and payload starts at BASE_ADDR+1.
REQ-002 Parameter MAX_BYTES, default 1518, is the largest accepted payload in bytes; legal range 1..4092.
REQ-003 Parameter HOLDOFF, default 2048, is the number of cycles ff_rx_rdy stays low after cmd_send.
REQ-004 clk_original  in  1  sole clock; all logic on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 ff_rx_data  in  8  Avalon-ST sink data byte.
REQ-007 ff_rx_dval  in  1  sink valid.
REQ-008 ff_rx_sop  in  1  start of packet.
REQ-009 ff_rx_eop  in  1  end of packet.
REQ-010 ff_rx_err  in  1  packet error, qualified with eop.
REQ-011 ff_rx_rdy  out  1  sink ready.
REQ-012 ram_addr  out  10  Avalon-MM master word address.
REQ-013 ram_chipselect, ram_write  out  1 each  write request.
REQ-014 ram_writedata  out  32  write data.
REQ-015 ram_byteenable  out  4  byte lanes.
REQ-016 ram_waitrequest  in  1  slave stall.
REQ-017 start_ram_addr  out  25  packet buffer address for send_packet_1, equal to zero-extended BASE_ADDR.
REQ-018 cmd_send  out  1  one-cycle pulse that starts send_packet_1.
REQ-019 rx_len  out  12  byte length of the last good packet.
REQ-020 rx_drop  out  1  one-cycle pulse when a packet is discarded.

Function
REQ-021 States: IDLE, RECV, WR_WORD, WR_HDR, SEND, HOLD, DISCARD.
REQ-022 A byte is accepted only in a cycle where ff_rx_dval=1 and ff_rx_rdy=1.
REQ-023 ff_rx_rdy=1 in IDLE, RECV and DISCARD; otherwise 0.
REQ-024 IDLE: an accepted byte with sop enters RECV as byte 0; an accepted byte without sop is discarded silently.
REQ-025 Bytes pack little-endian: byte n goes to lane n mod 4 (bits 8*(n mod 4)+7 : 8*(n mod 4)).
REQ-026 Accepting the 4th byte of a word, or the eop byte, enters WR_WORD.
REQ-027 The write is issued the next cycle at ram_addr = BASE_ADDR+1+n/4.
REQ-028 The byteenable for a partial last word covers only its valid lanes; unused lanes of ram_writedata are 0.
REQ-029 WR_WORD holds chipselect, write, address, data and byteenable stable until a cycle with ram_waitrequest=0; that cycle completes the write.
REQ-030 After a non-final write, the state returns to RECV; after the final write, it goes to WR_HDR.
REQ-031 WR_HDR writes {16'd0, 4'd0, len[11:0]} to BASE_ADDR with byteenable 4'hF and the same waitrequest rule, then goes to SEND.
REQ-032 SEND asserts cmd_send for exactly one cycle and updates rx_len, then enters HOLD.
REQ-033 HOLD counts HOLDOFF cycles, then returns to IDLE.
REQ-034 An eop with ff_rx_err=1 discards the packet: its final word is not written, there is no header write and no cmd_send, rx_drop pulses, and the state goes to IDLE.
REQ-035 A byte count exceeding MAX_BYTES pulses rx_drop and enters DISCARD, which accepts and drops bytes through eop and then goes to IDLE.
REQ-036 A sop in RECV pulses rx_drop and restarts capture with that byte as byte 0.
REQ-037 A single-byte packet (sop and eop together) writes one word with byteenable 4'b0001 and a header with length 1.
REQ-038 Lengths and addresses use 12-bit byte and 10-bit word arithmetic; BASE_ADDR+1+MAX_BYTES/4 must not wrap past 1023.

Reset
REQ-039 rst has priority over every other input, including during a stalled write.
REQ-040 Reset values: state IDLE, ff_rx_rdy 0 during reset, ram_chipselect 0, ram_write 0, ram_addr 0, ram_writedata 0, ram_byteenable 0, cmd_send 0, rx_drop 0, rx_len 0, counters 0.
REQ-041 A packet interrupted by reset is abandoned, with no header write and no cmd_send.

Verification
REQ-042 6-byte packet 01..06 with waitrequest=0: writes {04,03,02,01} BE F at BASE+1, {00,00,06,05} BE 3 at BASE+2, header 6 at BASE; then cmd_send one cycle, rx_len=6.
REQ-043 waitrequest held high 5 cycles on the first write: write signals stay stable, ff_rx_rdy=0, and no byte is lost.
REQ-044 Packet with eop+err: no header write, no cmd_send, rx_drop=1 for one cycle.
REQ-045 MAX_BYTES+1 bytes: rx_drop pulses, the remainder is drained, no cmd_send, and the next packet is captured correctly.
REQ-046 After cmd_send: ff_rx_rdy=0 for HOLDOFF cycles, then 1; a sop presented during HOLD is not accepted until IDLE.
REQ-047 rst asserted mid-WR_WORD with waitrequest=1: next cycle chipselect=0, state IDLE, and no cmd_send.
